// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache.
// Drives tag/valid/dirty/data/LRU array strobes and the physical-memory handshake, and keeps hit/miss counters.
module cache_control #(
    parameter int unsigned cnt_width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic [1:0]           hit,
    input  logic [1:0]           valid,
    input  logic [1:0]           dirty,
    input  logic                 lru,
    output logic                 arr_read,
    output logic [1:0]           data_load,
    output logic [1:0]           tag_load,
    output logic [1:0]           valid_load,
    output logic [1:0]           dirty_load,
    output logic                 dirty_in,
    output logic                 lru_load,
    output logic                 lru_in,
    output logic                 data_in_sel,
    output logic                 way_sel,
    output logic                 pmem_addr_sel,
    output logic [cnt_width-1:0] hit_count,
    output logic [cnt_width-1:0] miss_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOOKUP    = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    localparam logic [cnt_width-1:0] CNT_MAX = '1;
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic                 retry_q, retry_d;
    logic                 victim_q, victim_d;
    logic [cnt_width-1:0] hit_cnt_q, hit_cnt_d;
    logic [cnt_width-1:0] miss_cnt_q, miss_cnt_d;

    logic req, is_write, any_hit, hit_way;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write;
    assign any_hit  = |hit;
    // Both hit bits set resolves to way 0.
    assign hit_way  = ~hit[0];

    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        victim_d      = victim_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        arr_read      = 1'b0;
        data_load     = '0;
        tag_load      = '0;
        valid_load    = '0;
        dirty_load    = '0;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        data_in_sel   = 1'b0;
        way_sel       = 1'b0;
        pmem_addr_sel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    arr_read = 1'b1;
                    retry_d  = 1'b0;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (any_hit) begin
                    way_sel  = hit_way;
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_in   = ~hit_way;
                    if (is_write) begin
                        data_load[hit_way]  = 1'b1;
                        dirty_load[hit_way] = 1'b1;
                        dirty_in            = 1'b1;
                    end
                    if (!retry_q && hit_cnt_q != CNT_MAX)
                        hit_cnt_d = hit_cnt_q + CNT_ONE;
                    state_d = S_IDLE;
                end else begin
                    way_sel  = lru;
                    victim_d = lru;
                    if (!retry_q && miss_cnt_q != CNT_MAX)
                        miss_cnt_d = miss_cnt_q + CNT_ONE;
                    state_d = (valid[lru] & dirty[lru]) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                way_sel       = victim_q;
                pmem_addr_sel = 1'b1;
                pmem_write    = 1'b1;
                if (pmem_resp)
                    state_d = S_ALLOCATE;
            end
            default: begin
                way_sel   = victim_q;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_load[victim_q]  = 1'b1;
                    tag_load[victim_q]   = 1'b1;
                    valid_load[victim_q] = 1'b1;
                    dirty_load[victim_q] = 1'b1;
                    data_in_sel          = 1'b1;
                    arr_read             = 1'b1;
                    retry_d              = 1'b1;
                    state_d              = S_LOOKUP;
                end
            end
        endcase

        // Reset cycle issues no strobes or handshakes at all.
        if (rst) begin
            mem_resp      = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
            arr_read      = 1'b0;
            data_load     = '0;
            tag_load      = '0;
            valid_load    = '0;
            dirty_load    = '0;
            dirty_in      = 1'b0;
            lru_load      = 1'b0;
            lru_in        = 1'b0;
            data_in_sel   = 1'b0;
            way_sel       = 1'b0;
            pmem_addr_sel = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            retry_q    <= 1'b0;
            victim_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            victim_q   <= victim_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_control.sv
// Randomized transaction-level bench for cache_control: a CPU/memory model predicts every
// cycle's strobes from the cache protocol rules and tracks saturating hit/miss counts.
module tb_cache_control;

    localparam int unsigned CW  = 4;
    localparam int          MAX = 15;

    typedef struct packed {
        logic       mr, pr, pw, ar;
        logic [1:0] dl, tl, vl, yl;
        logic       di, ll, li, ds, ws, pa;
    } ov_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write, mem_resp;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [1:0]    hit, valid, dirty;
    logic          lru;
    logic          arr_read;
    logic [1:0]    data_load, tag_load, valid_load, dirty_load;
    logic          dirty_in, lru_load, lru_in, data_in_sel, way_sel, pmem_addr_sel;
    logic [CW-1:0] hit_count, miss_count;
    ov_t           outs;

    int n_vec = 0;
    int n_err = 0;
    int hits_m = 0;
    int miss_m = 0;

    cache_control #(.cnt_width(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit(hit), .valid(valid), .dirty(dirty), .lru(lru),
        .arr_read(arr_read), .data_load(data_load), .tag_load(tag_load),
        .valid_load(valid_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
        .lru_load(lru_load), .lru_in(lru_in), .data_in_sel(data_in_sel),
        .way_sel(way_sel), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign outs = {mem_resp, pmem_read, pmem_write, arr_read, data_load, tag_load,
                   valid_load, dirty_load, dirty_in, lru_load, lru_in, data_in_sel,
                   way_sel, pmem_addr_sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= MAX) ? MAX : c + 1;
    endfunction

    // Called at posedge+1: checks combinational outputs mid-cycle, then advances one clock.
    task automatic step_check(input string tag, input ov_t e);
        #2;
        check(tag, outs, e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hits"}, hit_count, hits_m);
        check({tag, "_miss"}, miss_count, miss_m);
    endtask

    task automatic garbage();
        hit   = 2'($urandom);
        valid = 2'($urandom);
        dirty = 2'($urandom);
        lru   = 1'($urandom);
    endtask

    task automatic hit_expect(input bit wr, input logic w, output ov_t e);
        e    = '0;
        e.mr = 1'b1;
        e.ws = w;
        e.ll = 1'b1;
        e.li = ~w;
        if (wr) begin
            e.dl = onehot(w);
            e.yl = onehot(w);
            e.di = 1'b1;
        end
    endtask

    // One complete CPU request; lat values count pmem cycles including the pmem_resp cycle.
    task automatic do_txn(input bit wr, input logic [1:0] h, input logic [1:0] vl,
                          input logic [1:0] dt, input logic lr,
                          input int unsigned wb_lat, input int unsigned fill_lat,
                          input int unsigned gap);
        ov_t  e;
        logic w, v;
        mem_write = wr;
        mem_read  = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        garbage();
        e = '0; e.ar = 1'b1;
        step_check("idle_req", e);

        hit = h; valid = vl; dirty = dt; lru = lr;
        if (h != 2'b00) begin
            w = h[0] ? 1'b0 : 1'b1;
            hit_expect(wr, w, e);
            step_check("lookup_hit", e);
            hits_m = sat_inc(hits_m);
        end else begin
            v = lr;
            e = '0; e.ws = v;
            step_check("lookup_miss", e);
            miss_m = sat_inc(miss_m);
            if (vl[v] && dt[v]) begin
                for (int unsigned i = 0; i < wb_lat; i++) begin
                    garbage();
                    pmem_resp = (i == wb_lat - 1);
                    e = '0; e.pw = 1'b1; e.pa = 1'b1; e.ws = v;
                    step_check("writeback", e);
                end
            end
            for (int unsigned i = 0; i < fill_lat; i++) begin
                garbage();
                pmem_resp = (i == fill_lat - 1);
                e = '0; e.pr = 1'b1; e.ws = v;
                if (pmem_resp) begin
                    e.dl = onehot(v); e.tl = onehot(v); e.vl = onehot(v); e.yl = onehot(v);
                    e.ds = 1'b1; e.ar = 1'b1;
                end
                step_check("allocate", e);
            end
            pmem_resp = 1'b0;
            garbage();
            hit = onehot(v);
            hit_expect(wr, v, e);
            step_check("retry_hit", e);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_counts("after_txn");
        for (int unsigned i = 0; i < gap; i++) begin
            garbage();
            step_check("idle", '0);
        end
    endtask

    initial begin
        ov_t e;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit = '0; valid = '0; dirty = '0; lru = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        #2 check("reset_outs", outs, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_counts("reset");

        do_txn(1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 1, 1, 1);
        do_txn(1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1, 1, 0);
        do_txn(1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1, 5, 1);
        do_txn(1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 3, 2, 1);
        do_txn(1'b0, 2'b11, 2'b11, 2'b11, 1'b1, 1, 1, 0);

        // Reset arriving while a fill is outstanding, with pmem_resp in the same cycle.
        mem_read = 1'b1;
        step_check("rst_idle_req", 18'h0 | (1 << 14));
        hit = 2'b00; valid = 2'b00; dirty = 2'b00; lru = 1'b1;
        e = '0; e.ws = 1'b1;
        step_check("rst_lookup_miss", e);
        e = '0; e.pr = 1'b1; e.ws = 1'b1;
        step_check("rst_alloc", e);
        rst = 1'b1;
        pmem_resp = 1'b1;
        #2 check("rst_no_loads", {outs.dl, outs.tl, outs.vl, outs.yl, outs.ll}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b0;
        hits_m = 0; miss_m = 0;
        step_check("post_rst_idle", '0);
        check_counts("post_rst");

        for (int i = 0; i < 17; i++)
            do_txn(1'($urandom), 2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
                   1'($urandom), 1, 1, 0);
        check("hit_sat", hit_count, 4'hF);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] h;
            h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            do_txn(1'($urandom), h, 2'($urandom), 2'($urandom), 1'($urandom),
                   $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache.
- Sits directly upstream of the cache's per-way tag/valid/dirty/data arrays and the per-set LRU array.
- Drives their read/load strobes from CPU requests and physical-memory handshakes.
- Datapath supplies per-way hit/valid/dirty and the LRU bit; this block also keeps hit/miss performance counters.

Parameters:
cnt_width, 32, width of hit_count and miss_count (saturating)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request; held with address until mem_resp
mem_write  in  1  CPU write request; held with address/data/byte-enables until mem_resp
mem_resp  out  1  one-cycle CPU completion pulse
pmem_read  out  1  line fill request; held until pmem_resp
pmem_write  out  1  line writeback request; held until pmem_resp
pmem_resp  in  1  physical memory completion pulse
hit  in  2  per-way valid&tag-match, meaningful in LOOKUP
valid  in  2  per-way valid bits of indexed set, meaningful in LOOKUP
dirty  in  2  per-way dirty bits of indexed set, meaningful in LOOKUP
lru  in  1  way to evict for indexed set
arr_read  out  1  read strobe to all arrays (registered outputs next cycle)
data_load  out  2  per-way data array load
tag_load  out  2  per-way tag array load
valid_load  out  2  per-way valid array load (valid_in tied 1 in datapath)
dirty_load  out  2  per-way dirty array load
dirty_in  out  1  value written to dirty array
lru_load  out  1  LRU array load
lru_in  out  1  value written to LRU array
data_in_sel  out  1  0 = CPU write-merge line, 1 = pmem fill line
way_sel  out  1  way selected for CPU read mux, victim tag and writeback data
pmem_addr_sel  out  1  0 = {cpu tag,index,offset 0}, 1 = {victim tag,index,offset 0}
hit_count  out  cnt_width  first-lookup hits since reset
miss_count  out  cnt_width  first-lookup misses since reset

Behaviour:
- Reset: state IDLE, retry flag 0, counters 0. All strobes, mem_resp, pmem_read and pmem_write are 0. way_sel, pmem_addr_sel and data_in_sel are 0.
- Outputs are combinational from state and inputs. Any output not listed for a state is 0.
- Arrays have 1-cycle registered read. A read issued together with a load at the same index returns the loaded data.
- IDLE:
  - If mem_read|mem_write: assert arr_read, go to LOOKUP, clear retry.
  - Otherwise stay in IDLE.
  - mem_read and mem_write both high is illegal; treat it as a write.
- LOOKUP, hit (exactly one hit bit set; way w = its index):
  - way_sel=w, mem_resp=1.
  - lru_load=1, lru_in=~w.
  - On write, also: data_load[w]=1, data_in_sel=0, dirty_load[w]=1, dirty_in=1.
  - Go to IDLE.
  - If retry=0, increment hit_count.
- LOOKUP, miss (v = lru):
  - way_sel=v.
  - If retry=0, increment miss_count.
  - If valid[v]&dirty[v], go to WRITEBACK; else go to ALLOCATE.
- WRITEBACK:
  - way_sel=v, pmem_addr_sel=1, pmem_write=1.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - way_sel=v, pmem_addr_sel=0, pmem_read=1.
  - On pmem_resp: data_load[v], tag_load[v] and valid_load[v] all =1; dirty_load[v]=1 with dirty_in=0; data_in_sel=1; arr_read=1.
  - On pmem_resp, also set retry=1 and go to LOOKUP. The retry lookup hits in way v, so a write miss merges its data there.
- The victim way is latched on entry to WRITEBACK/ALLOCATE and stays stable until the retry LOOKUP.
- pmem_read and pmem_write are never high together. Each drops the cycle after pmem_resp.
- Counters saturate at all-ones. A retry LOOKUP is never counted.
- mem_resp is exactly one cycle per request. A new request is accepted no earlier than the cycle after mem_resp.
- rst mid-operation returns to IDLE next edge and drops pmem_read/pmem_write. No array load is issued in the reset cycle.
- Two hit bits set is illegal; resolve to way 0.

Test Plan:
- Reset, then read with hit=2'b10 in LOOKUP -> arr_read in cycle 1; cycle 2 mem_resp=1, way_sel=1, lru_load=1, lru_in=0; hit_count=1, miss_count=0.
- Write hit in way 0 -> mem_resp, data_load=2'b01, dirty_load=2'b01, dirty_in=1, lru_in=1; total latency 2 cycles.
- Read miss with lru=1, valid=2'b10, dirty=2'b00 -> ALLOCATE, pmem_read held 5 cycles until pmem_resp; then data/tag/valid_load=2'b10, dirty_in=0, arr_read=1; retry hit gives mem_resp; miss_count=1, hit_count unchanged.
- Write miss with lru=0, valid=2'b01, dirty=2'b01 -> pmem_write with pmem_addr_sel=1 until pmem_resp; then pmem_read with pmem_addr_sel=0; then retry write hit: dirty_in=1, data_in_sel=0, mem_resp.
- rst asserted during ALLOCATE with pmem_read high -> next cycle pmem_read=0, state IDLE, counters 0, no load strobes.
- Force hit_count to all-ones (cnt_width=4 build, 16 hits) -> hit_count stays 4'hF.
